// File: rtl/instruction_fetch.sv
// Fetch stage: PC generation, in-order imem requests, and a credit-limited instruction buffer toward decode.
// Optional perf counters are enabled by defining FETCH_PERF_COUNTER_EN.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instruction,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_COUNTER_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubble,
    output logic [31:0] perf_redirect
`endif
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(FIFO_DEPTH);
    localparam cnt_t CNT_ONE = cnt_t'(1);
    localparam ptr_t PTR_ONE = ptr_t'(1);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    cnt_t        outstanding_q, outstanding_d;
    cnt_t        drop_count_q, drop_count_d;
    cnt_t        fifo_count_q, fifo_count_d;
    ptr_t        fifo_rd_ptr_q, fifo_rd_ptr_d;
    ptr_t        fifo_wr_ptr_q, fifo_wr_ptr_d;
    ptr_t        tag_rd_ptr_q, tag_rd_ptr_d;
    ptr_t        tag_wr_ptr_q, tag_wr_ptr_d;

    logic [31:0] fifo_pc_q  [FIFO_DEPTH];
    logic [31:0] fifo_ins_q [FIFO_DEPTH];
    logic [31:0] tag_pc_q   [FIFO_DEPTH];

    logic        req_fire;
    logic        out_fire;
    logic        rsp_drop;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic [CW:0] credit_used;

    always_comb begin
        credit_used     = {1'b0, outstanding_q} + {1'b0, fifo_count_q};
        imem_req_valid  = !reset && !redirect_valid && (credit_used < {1'b0, DEPTH_C});
        imem_addr       = fetch_pc_q;
        req_fire        = imem_req_valid && imem_req_ready;

        out_valid       = (fifo_count_q != '0);
        out_instruction = out_valid ? fifo_ins_q[fifo_rd_ptr_q] : '0;
        out_pc          = out_valid ? fifo_pc_q[fifo_rd_ptr_q] : '0;
        out_fire        = out_valid && out_ready;

        fifo_full       = (fifo_count_q == DEPTH_C);
        rsp_drop        = imem_rsp_valid && (drop_count_q != '0);
        fifo_push       = imem_rsp_valid && !rsp_drop && !redirect_valid;
        fifo_pop        = out_fire && !redirect_valid;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        drop_count_d  = drop_count_q;
        fifo_count_d  = fifo_count_q;
        fifo_rd_ptr_d = fifo_rd_ptr_q;
        fifo_wr_ptr_d = fifo_wr_ptr_q;
        tag_rd_ptr_d  = tag_rd_ptr_q;
        tag_wr_ptr_d  = tag_wr_ptr_q;

        if (req_fire) begin
            fetch_pc_d   = fetch_pc_q + 32'd4;
            tag_wr_ptr_d = tag_wr_ptr_q + PTR_ONE;
        end
        if (imem_rsp_valid) begin
            tag_rd_ptr_d = tag_rd_ptr_q + PTR_ONE;
        end

        case ({req_fire, imem_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CNT_ONE;
            2'b01:   outstanding_d = outstanding_q - CNT_ONE;
            default: outstanding_d = outstanding_q;
        endcase

        if (fifo_push) begin
            fifo_wr_ptr_d = fifo_wr_ptr_q + PTR_ONE;
        end
        if (fifo_pop) begin
            fifo_rd_ptr_d = fifo_rd_ptr_q + PTR_ONE;
        end
        case ({fifo_push, fifo_pop})
            2'b10:   fifo_count_d = fifo_count_q + CNT_ONE;
            2'b01:   fifo_count_d = fifo_count_q - CNT_ONE;
            default: fifo_count_d = fifo_count_q;
        endcase

        if (rsp_drop) begin
            drop_count_d = drop_count_q - CNT_ONE;
        end

        // Every request still in flight after a redirect is stale; existing drops are already inside outstanding.
        if (redirect_valid) begin
            fetch_pc_d    = redirect_pc & 32'hFFFF_FFFC;
            drop_count_d  = imem_rsp_valid ? (outstanding_q - CNT_ONE) : outstanding_q;
            fifo_count_d  = '0;
            fifo_rd_ptr_d = '0;
            fifo_wr_ptr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_count_q  <= '0;
            fifo_count_q  <= '0;
            fifo_rd_ptr_q <= '0;
            fifo_wr_ptr_q <= '0;
            tag_rd_ptr_q  <= '0;
            tag_wr_ptr_q  <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_count_q  <= drop_count_d;
            fifo_count_q  <= fifo_count_d;
            fifo_rd_ptr_q <= fifo_rd_ptr_d;
            fifo_wr_ptr_q <= fifo_wr_ptr_d;
            tag_rd_ptr_q  <= tag_rd_ptr_d;
            tag_wr_ptr_q  <= tag_wr_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_pc_q[fifo_wr_ptr_q]  <= tag_pc_q[tag_rd_ptr_q];
            fifo_ins_q[fifo_wr_ptr_q] <= imem_rsp_data;
        end
        if (req_fire) begin
            tag_pc_q[tag_wr_ptr_q] <= fetch_pc_q;
        end
    end

    a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
        !(fifo_push && fifo_full && !fifo_pop));

`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_bubble_q, perf_bubble_d;
    logic [31:0] perf_redirect_q, perf_redirect_d;

    always_comb begin
        perf_fetched_d  = perf_fetched_q + (out_fire ? 32'd1 : 32'd0);
        perf_bubble_d   = perf_bubble_q + (out_valid ? 32'd0 : 32'd1);
        perf_redirect_d = perf_redirect_q + (redirect_valid ? 32'd1 : 32'd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q  <= '0;
            perf_bubble_q   <= '0;
            perf_redirect_q <= '0;
        end else begin
            perf_fetched_q  <= perf_fetched_d;
            perf_bubble_q   <= perf_bubble_d;
            perf_redirect_q <= perf_redirect_d;
        end
    end

    assign perf_fetched  = perf_fetched_q;
    assign perf_bubble   = perf_bubble_q;
    assign perf_redirect = perf_redirect_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: expected request addresses and delivered PCs are queued by the
// stimulus and popped by an independent monitor; a behavioural memory answers requests in order.
module tb_instruction_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_COUNTER_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubble;
    logic [31:0] perf_redirect;
`endif

    instruction_fetch #(
        .RESET_PC  (32'h0000_0100),
        .FIFO_DEPTH(4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instruction(out_instruction),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_COUNTER_EN
        ,
        .perf_fetched   (perf_fetched),
        .perf_bubble    (perf_bubble),
        .perf_redirect  (perf_redirect)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_checks = 0;
    int passed_checks = 0;
    int cyc = 0;
    int req_count = 0;
    int delivered = 0;
    int raw_hs = 0;
    int ov_cnt = 0;
    int fixed_lat = 1;
    logic rand_mode = 1'b0;
    logic ready_ctl = 1'b1;
    logic rnd_ready = 1'b1;

    logic [31:0] exp_pc[$];
    logic [31:0] exp_addr[$];

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;
    pend_t pend[$];

    assign imem_req_ready = rand_mode ? rnd_ready : ready_ctl;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_checks++;
        if (act === exp) passed_checks++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        total_checks++;
        $display("FAIL %s", name);
    endtask

    task automatic fill_queues(input logic [31:0] base);
        exp_pc.delete();
        exp_addr.delete();
        for (int i = 0; i < 256; i++) begin
            exp_pc.push_back(base + 32'(4 * i));
            exp_addr.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("reset_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("reset_out_valid", {31'd0, out_valid}, 32'd0);
        check("reset_out_instruction", out_instruction, 32'd0);
        check("reset_out_pc", out_pc, 32'd0);
`ifdef FETCH_PERF_COUNTER_EN
        check("reset_perf_fetched", perf_fetched, 32'd0);
        check("reset_perf_bubble", perf_bubble, 32'd0);
        check("reset_perf_redirect", perf_redirect, 32'd0);
`endif
        fill_queues(32'h0000_0100);
        req_count = 0;
        delivered = 0;
        raw_hs = 0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc = target;
        fill_queues(target & 32'hFFFF_FFFC);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural memory: in-order responses, at most one per cycle, latency >= 1.
    initial begin
        pend_t p;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                p.addr = imem_addr;
                p.due = cyc + (rand_mode ? int'($urandom_range(1, 5)) : fixed_lat);
                pend.push_back(p);
                req_count++;
            end
            @(posedge clk);
            #1;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data = mem_word(pend[0].addr);
                void'(pend.pop_front());
            end else begin
                imem_rsp_valid = 1'b0;
                imem_rsp_data = '0;
            end
            rnd_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial forever begin
        logic [31:0] e;
        @(negedge clk);
        if (!reset) begin
            if (redirect_valid) begin
                check("no_req_in_redirect", {31'd0, imem_req_valid}, 32'd0);
            end else if (imem_req_valid && imem_req_ready) begin
                if (exp_addr.size() == 0) fail_now("unexpected_request");
                else check("imem_addr", imem_addr, exp_addr.pop_front());
            end
            if (out_valid && out_ready) raw_hs++;
            if (out_valid && out_ready && !redirect_valid) begin
                if (exp_pc.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = exp_pc.pop_front();
                    check("out_pc", out_pc, e);
                    check("out_instruction", out_instruction, mem_word(e));
                end
                delivered++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        out_ready = 1'b0;

        // Streaming from reset with a 1-cycle memory.
        out_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("t1_first_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t1_first_addr", imem_addr, 32'h0000_0100);
        check("t1_out_valid_n0", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_out_valid_n1", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t1_out_valid_n2", {31'd0, out_valid}, 32'd1);
        check("t1_first_out_pc", out_pc, 32'h0000_0100);
        ov_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) ov_cnt++;
        end
        check("t1_throughput", 32'(ov_cnt), 32'd8);

        // Consumer stalled: credits cap requests at the buffer depth.
        out_ready = 1'b0;
        do_reset();
        repeat (10) @(negedge clk);
        check("t2_req_count", 32'(req_count), 32'd4);
        check("t2_req_valid_blocked", {31'd0, imem_req_valid}, 32'd0);
        check("t2_out_valid", {31'd0, out_valid}, 32'd1);
        check("t2_out_pc_hold", out_pc, 32'h0000_0100);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (12) @(negedge clk);
        check("t2_drained", {31'd0, (delivered >= 4)}, 32'd1);

        // Redirect with two requests in flight and one buffered.
        out_ready = 1'b0;
        ready_ctl = 1'b1;
        fixed_lat = 3;
        do_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ready_ctl = 1'b0;
        @(posedge clk); #1;
        redirect_to(32'h0000_2002);
        ready_ctl = 1'b1;
        @(negedge clk);
        check("t3_buffered_valid", {31'd0, out_valid}, 32'd1);
        check("t3_buffered_pc", out_pc, 32'h0000_0100);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("t3_target_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t3_target_addr", imem_addr, 32'h0000_2000);
        check("t3_flushed", {31'd0, out_valid}, 32'd0);
        repeat (20) @(negedge clk);
        check("t3_progress", {31'd0, (delivered >= 4)}, 32'd1);

        // Random memory latency, request ready and consumer ready.
        rand_mode = 1'b1;
        out_ready = 1'b1;
        do_reset();
        repeat (300) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(0, 2) != 0);
        end
        out_ready = 1'b0;
        rand_mode = 1'b0;
        @(negedge clk);
        check("t4_progress", {31'd0, (delivered >= 30)}, 32'd1);

        // Back-to-back redirects: the second target wins.
        fixed_lat = 1;
        ready_ctl = 1'b1;
        out_ready = 1'b1;
        do_reset();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        redirect_to(32'h0000_0040);
        @(posedge clk); #1;
        redirect_to(32'h0000_0080);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        @(negedge clk);
        check("t5_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("t5_addr", imem_addr, 32'h0000_0080);
        @(negedge clk);
        check("t5_out_valid_r2", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("t5_out_valid_r3", {31'd0, out_valid}, 32'd1);
        check("t5_first_pc", out_pc, 32'h0000_0080);
        repeat (10) @(negedge clk);
`ifdef FETCH_PERF_COUNTER_EN
        check("perf_redirect", perf_redirect, 32'd2);
        check("perf_fetched", perf_fetched, 32'(raw_hs));
`endif

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Holds the program counter and issues word requests to instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions with their PC and presents them to decode over a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and discards stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC of the first fetch after reset.
- FIFO_DEPTH, 4, instruction buffer entries, also the cap on outstanding plus buffered fetches; power of two, >=2.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  byte address of request, bits [1:0] always 0.
- imem_rsp_valid  input  1  one pulse per accepted request, in order, latency >=1 cycle.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  execute resolves a control transfer.
- redirect_pc  input  32  target PC.
- out_valid  output  1  instruction available to decoder.
- out_ready  input  1  decoder accepts.
- out_instruction  output  32  instruction word to decoder.
- out_pc  output  32  PC of out_instruction.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_PC; outstanding = 0; drop_count = 0; FIFO empty.
  - imem_req_valid = 0, out_valid = 0, out_instruction = 0, out_pc = 0.
  - Reset mid-operation abandons all in-flight requests. Responses arriving after reset are not dropped; the memory must be reset with this block.
- Request issue:
  - imem_req_valid = !reset && !redirect_valid && (outstanding + fifo_count) < FIFO_DEPTH.
  - imem_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (wraps modulo 2^32), push fetch_pc into the PC tag queue, outstanding += 1.
- Response:
  - On imem_rsp_valid with drop_count > 0: discard the response, drop_count -= 1, outstanding -= 1, pop the tag queue.
  - Otherwise push {tag head, imem_rsp_data} into the FIFO, pop the tag, outstanding -= 1.
  - The credit rule guarantees the FIFO is never pushed while full. A push to a full FIFO is a protocol violation; assert it in simulation.
- Output:
  - out_valid = FIFO non-empty. out_instruction and out_pc show the FIFO head.
  - Transfer on out_valid && out_ready pops the head.
  - While out_valid && !out_ready, outputs hold stable.
  - Push and pop in the same cycle are allowed, including when the FIFO is full.
- Redirect (highest priority):
  - In the redirect cycle: FIFO is flushed and the pop is ignored; the consumer also flushes.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - drop_count <= outstanding, minus 1 if a response arrives this cycle, plus any existing non-zero drop_count already folded into outstanding.
  - No request is issued in the redirect cycle.
  - First request to the target is issued the next cycle.
  - Back-to-back redirects: the last one wins.
- Latency with a 1-cycle memory and imem_req_ready = 1:
  - Request in cycle N, out_valid in cycle N+2.
  - Steady-state throughput is 1 instruction per cycle.
  - Redirect-to-target out_valid is 3 cycles.
- Counter widths: outstanding, drop_count and fifo_count are each $clog2(FIFO_DEPTH)+1 bits and never exceed FIFO_DEPTH.

Optional Feature:
- Macro: FETCH_PERF_COUNTER_EN.
- Defined: adds three outputs.
  - perf_fetched (32): increments on each out handshake.
  - perf_bubble (32): increments each cycle out_valid = 0 and reset = 0.
  - perf_redirect (32): increments on each redirect_valid.
  - All three clear on reset and wrap modulo 2^32.
- Not defined: ports and logic absent; all other behaviour identical.

Test Plan:
- Reset release, RESET_PC = 0x100, 1-cycle memory, out_ready = 1 -> imem_addr 0x100, 0x104, 0x108... on consecutive cycles; first out_valid 2 cycles after first request with out_pc = 0x100; then one instruction per cycle.
- out_ready = 0 for 10 cycles -> at most 4 requests issued, then imem_req_valid = 0; out_pc holds 0x100. Release -> PCs 0x100..0x10C delivered in order with no loss or duplicate.
- Redirect to 0x2002 while 2 requests are outstanding and 1 is buffered -> both stale responses dropped, FIFO flushed; next imem_addr = 0x2000; next delivered out_pc = 0x2000.
- Memory with random 1-5 cycle latency and random imem_req_ready -> delivered PC sequence strictly +4; each out_instruction matches the memory model at out_pc.
- Redirect on consecutive cycles to 0x40 then 0x80 -> no output from 0x40; first delivered out_pc = 0x80.
- FETCH_PERF_COUNTER_EN defined, 20 instructions delivered and 1 redirect -> perf_fetched = 20, perf_redirect = 1; all counters 0 after reset.
